// File: rtl/ad_pkg.sv
// Shared encodings and helpers for the ADC channel scheduler.
package ad_pkg;
  localparam int AD_WIDTH = 12;
  localparam int AD_NCH   = 8;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_SCAN4  = 2'b01,
    MODE_SCAN8  = 2'b10,
    MODE_PAUSE  = 2'b11
  } ad_mode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    STORE     = 2'd2
  } ad_state_e;

  // Next channel in scan order; single and pause modes keep the pointer.
  function automatic logic [2:0] ch_advance(input ad_mode_e m, input logic [2:0] ch);
    case (m)
      MODE_SCAN4: ch_advance = {1'b0, ch[1:0] + 2'd1};
      MODE_SCAN8: ch_advance = ch + 3'd1;
      default:    ch_advance = ch;
    endcase
  endfunction
endpackage

// File: rtl/ad_sample_timer.sv
// Free-running sample-rate divider; one-cycle tick every SAMPLE_PERIOD cycles.
module ad_sample_timer #(
  parameter int SAMPLE_PERIOD = 5000
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!en || tick) cnt_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ad_scan_scheduler.sv
// Paces ADC requests, picks channel per scan mode, checks echoed address and
// keeps the latest result per channel.
module ad_scan_scheduler
  import ad_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 5000,
  parameter int TIMEOUT       = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          Switch,
  input  logic [2:0]          Sel_Ch,
  output logic                Conv_Start,
  output logic [2:0]          Conv_Addr,
  input  logic                Conv_Busy,
  input  logic                Conv_Done,
  input  logic [AD_WIDTH-1:0] Conv_Data,
  input  logic [2:0]          Conv_RetAddr,
  output logic                Res_Valid,
  output logic [2:0]          Res_Addr,
  output logic [AD_WIDTH-1:0] Res_Data,
  input  logic [2:0]          Rd_Addr,
  output logic [AD_WIDTH-1:0] Rd_Data,
  input  logic                Err_Clr,
  output logic                Err_Addr,
  output logic                Err_Timeout,
  output logic                Overrun
);
  localparam int TW = $clog2(TIMEOUT + 1);

  ad_mode_e  mode;
  ad_state_e state_q, state_d;
  logic      tick, addr_ok, tmo_hit, wr_en, ch_adv;
  logic      ev_addr, ev_tmo, ev_ovr;
  logic [2:0] ch_q, ch_d, req_ch;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [AD_WIDTH-1:0] data_q, data_d;
  logic conv_start_q, conv_start_d, res_valid_q, res_valid_d;
  logic [2:0] conv_addr_q, conv_addr_d, res_addr_q, res_addr_d;
  logic [AD_WIDTH-1:0] res_data_q, res_data_d;
  logic err_addr_q, err_addr_d, err_tmo_q, err_tmo_d, ovr_q, ovr_d;
  logic [AD_WIDTH-1:0] file_q [AD_NCH];

  assign mode = ad_mode_e'(Switch);

  ad_sample_timer #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_timer (
    .CLK (CLK),
    .RST (RST),
    .en  (mode != MODE_PAUSE),
    .tick(tick)
  );

  assign addr_ok = (Conv_RetAddr == conv_addr_q);
  assign tmo_hit = (tmo_q == TW'(TIMEOUT));
  // A stale pointer left over from a wider scan requests channel 0, matching the forced reset below.
  assign req_ch  = (mode == MODE_SCAN4 && ch_q[2]) ? 3'd0 : ch_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (tick && !Conv_Busy) state_d = WAIT_DONE;
      WAIT_DONE: if (Conv_Done)          state_d = addr_ok ? STORE : IDLE;
                 else if (tmo_hit)       state_d = IDLE;
      STORE:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    conv_start_d = 1'b0;
    conv_addr_d  = conv_addr_q;
    res_valid_d  = 1'b0;
    res_addr_d   = res_addr_q;
    res_data_d   = res_data_q;
    data_d       = data_q;
    tmo_d        = tmo_q;
    wr_en        = 1'b0;
    ch_adv       = 1'b0;
    ev_addr      = 1'b0;
    ev_tmo       = 1'b0;
    ev_ovr       = 1'b0;
    case (state_q)
      IDLE: if (tick) begin
        if (Conv_Busy) ev_ovr = 1'b1;
        else begin
          conv_start_d = 1'b1;
          conv_addr_d  = (mode == MODE_SINGLE) ? Sel_Ch : req_ch;
          tmo_d        = '0;
        end
      end
      WAIT_DONE: begin
        tmo_d  = tmo_q + TW'(1);
        ev_ovr = tick;
        if (Conv_Done) begin
          if (addr_ok) data_d = Conv_Data;
          else begin
            ev_addr = 1'b1;
            ch_adv  = 1'b1;
          end
        end else if (tmo_hit) begin
          ev_tmo = 1'b1;
          ch_adv = 1'b1;
        end
      end
      STORE: begin
        wr_en       = 1'b1;
        res_valid_d = 1'b1;
        res_addr_d  = conv_addr_q;
        res_data_d  = data_q;
        ch_adv      = 1'b1;
        ev_ovr      = tick;  // result not yet retired, so a tick here is lost too
      end
      default: ;
    endcase
    ch_d = ch_q;
    if (mode == MODE_SCAN4 && ch_q[2]) ch_d = 3'd0;
    else if (ch_adv)                   ch_d = ch_advance(mode, ch_q);
    err_addr_d = (err_addr_q & ~Err_Clr) | ev_addr;
    err_tmo_d  = (err_tmo_q  & ~Err_Clr) | ev_tmo;
    ovr_d      = (ovr_q      & ~Err_Clr) | ev_ovr;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      conv_start_q <= 1'b0;
      conv_addr_q  <= '0;
      res_valid_q  <= 1'b0;
      res_addr_q   <= '0;
      res_data_q   <= '0;
      data_q       <= '0;
      tmo_q        <= '0;
      ch_q         <= '0;
      err_addr_q   <= 1'b0;
      err_tmo_q    <= 1'b0;
      ovr_q        <= 1'b0;
      for (int i = 0; i < AD_NCH; i++) file_q[i] <= '0;
    end else begin
      conv_start_q <= conv_start_d;
      conv_addr_q  <= conv_addr_d;
      res_valid_q  <= res_valid_d;
      res_addr_q   <= res_addr_d;
      res_data_q   <= res_data_d;
      data_q       <= data_d;
      tmo_q        <= tmo_d;
      ch_q         <= ch_d;
      err_addr_q   <= err_addr_d;
      err_tmo_q    <= err_tmo_d;
      ovr_q        <= ovr_d;
      if (wr_en) file_q[conv_addr_q] <= data_q;
    end
  end

  assign Conv_Start  = conv_start_q;
  assign Conv_Addr   = conv_addr_q;
  assign Res_Valid   = res_valid_q;
  assign Res_Addr    = res_addr_q;
  assign Res_Data    = res_data_q;
  assign Rd_Data     = file_q[Rd_Addr];
  assign Err_Addr    = err_addr_q;
  assign Err_Timeout = err_tmo_q;
  assign Overrun     = ovr_q;
endmodule

// File: tb/tb_ad_scan_scheduler.sv
// Directed bench for ad_scan_scheduler: vector table for scan/single modes,
// hand sequences for mismatch, timeout, overrun/pause and reset mid-frame.
module tb_ad_scan_scheduler;
  localparam int SP = 20;
  localparam int TO = 8;
  localparam int NV = 12;

  logic        CLK = 1'b0, RST = 1'b1;
  logic [1:0]  Switch = 2'b01;
  logic [2:0]  Sel_Ch = '0, Conv_RetAddr = '0, Rd_Addr = '0;
  logic        Conv_Busy = 1'b0, Conv_Done = 1'b0, Err_Clr = 1'b0;
  logic [11:0] Conv_Data = '0;
  logic        Conv_Start, Res_Valid, Err_Addr, Err_Timeout, Overrun;
  logic [2:0]  Conv_Addr, Res_Addr;
  logic [11:0] Res_Data, Rd_Data;

  ad_scan_scheduler #(.SAMPLE_PERIOD(SP), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .Switch(Switch), .Sel_Ch(Sel_Ch),
    .Conv_Start(Conv_Start), .Conv_Addr(Conv_Addr), .Conv_Busy(Conv_Busy),
    .Conv_Done(Conv_Done), .Conv_Data(Conv_Data), .Conv_RetAddr(Conv_RetAddr),
    .Res_Valid(Res_Valid), .Res_Addr(Res_Addr), .Res_Data(Res_Data),
    .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data), .Err_Clr(Err_Clr),
    .Err_Addr(Err_Addr), .Err_Timeout(Err_Timeout), .Overrun(Overrun)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct {
    logic [1:0]  sw;
    logic [2:0]  sel;
    logic [2:0]  exp_addr;
    logic [11:0] data;
  } vec_t;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_start(input int budget, output int s);
    s = -1;
    for (int k = 0; k < budget; k++) begin
      step(1);
      if (Conv_Start) begin
        s = cyc;
        break;
      end
    end
    checks++;
    if (s < 0) begin
      failures++;
      $display("FAIL start_wait: got none expected Conv_Start within %0d cycles", budget);
    end
  endtask

  // Engine model: busy for the frame, Done after lat cycles; returns Done cycle.
  task automatic respond(input logic [2:0] ret, input logic [11:0] data, input int lat, output int d);
    Conv_Busy = 1'b1;
    step(lat);
    Conv_Done = 1'b1;
    Conv_RetAddr = ret;
    Conv_Data = data;
    d = cyc;
    step(1);
    Conv_Done = 1'b0;
    Conv_Busy = 1'b0;
  endtask

  task automatic count_starts(input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      step(1);
      if (Conv_Start) c++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, prev_s, d, n;
    tbl[0]  = '{2'b01, 3'd0, 3'd0, 12'h100};
    tbl[1]  = '{2'b01, 3'd0, 3'd1, 12'h101};
    tbl[2]  = '{2'b01, 3'd0, 3'd2, 12'h102};
    tbl[3]  = '{2'b01, 3'd0, 3'd3, 12'h103};
    tbl[4]  = '{2'b01, 3'd0, 3'd0, 12'h100};
    tbl[5]  = '{2'b00, 3'd6, 3'd6, 12'hABC};
    tbl[6]  = '{2'b00, 3'd6, 3'd6, 12'hABC};
    tbl[7]  = '{2'b10, 3'd0, 3'd1, 12'h101};
    tbl[8]  = '{2'b10, 3'd0, 3'd2, 12'h102};
    tbl[9]  = '{2'b10, 3'd0, 3'd3, 12'h103};
    tbl[10] = '{2'b10, 3'd0, 3'd4, 12'h104};
    tbl[11] = '{2'b01, 3'd0, 3'd0, 12'h100};  // ch=5 left by scan8 is forced to 0

    step(3);
    chk("rst_conv_start", Conv_Start, 0);
    chk("rst_outputs", {Conv_Addr, Res_Valid, Res_Addr, Res_Data, Err_Addr, Err_Timeout, Overrun}, 0);
    chk("rst_rd_data", Rd_Data, 0);
    @(negedge CLK);
    RST = 1'b0;

    prev_s = 0;
    for (int i = 0; i < NV; i++) begin
      Switch = tbl[i].sw;
      Sel_Ch = tbl[i].sel;
      Rd_Addr = tbl[i].exp_addr;
      wait_start(40, s);
      chk($sformatf("v%0d_addr", i), Conv_Addr, tbl[i].exp_addr);
      if (i > 0) chk($sformatf("v%0d_spacing", i), s - prev_s, SP);
      prev_s = s;
      respond(Conv_Addr, tbl[i].data, 3, d);
      chk($sformatf("v%0d_res_valid_d1", i), Res_Valid, 0);
      step(1);
      chk($sformatf("v%0d_res_valid_d2", i), Res_Valid, 1);
      chk($sformatf("v%0d_res_data", i), Res_Data, tbl[i].data);
      chk($sformatf("v%0d_res_addr", i), Res_Addr, tbl[i].exp_addr);
      chk($sformatf("v%0d_rd_data", i), Rd_Data, tbl[i].data);
    end
    Rd_Addr = 3'd2;
    #1 chk("rd_addr2", Rd_Data, 12'h102);
    Rd_Addr = 3'd6;
    #1 chk("rd_addr6", Rd_Data, 12'hABC);
    Rd_Addr = 3'd7;
    #1 chk("rd_addr7", Rd_Data, 0);

    // Address mismatch: request 3, engine echoes 5.
    Switch = 2'b00;
    Sel_Ch = 3'd3;
    Rd_Addr = 3'd3;
    wait_start(40, s);
    chk("mm_addr", Conv_Addr, 3);
    respond(3'd5, 12'hEEE, 3, d);
    chk("mm_err_addr", Err_Addr, 1);
    chk("mm_no_valid_d1", Res_Valid, 0);
    step(1);
    chk("mm_no_valid_d2", Res_Valid, 0);
    chk("mm_file_kept", Rd_Data, 12'h103);
    Err_Clr = 1'b1;
    step(1);
    Err_Clr = 1'b0;
    chk("mm_err_cleared", Err_Addr, 0);

    // Timeout: no Done; Err_Clr coinciding with the abort loses to the event.
    Switch = 2'b01;
    wait_start(40, s);
    prev_s = s;
    chk("to_addr", Conv_Addr, 1);
    step(8);
    chk("to_not_yet", Err_Timeout, 0);
    Err_Clr = 1'b1;
    step(1);
    Err_Clr = 1'b0;
    chk("to_set_over_clr", Err_Timeout, 1);
    wait_start(40, s);
    chk("to_next_addr", Conv_Addr, 2);
    chk("to_spacing", s - prev_s, SP);
    respond(Conv_Addr, 12'h102, 3, d);
    step(1);
    chk("to_next_valid", Res_Valid, 1);

    // Overrun: engine busy across a tick in IDLE.
    chk("ovr_clear_before", Overrun, 0);
    Conv_Busy = 1'b1;
    count_starts(25, n);
    Conv_Busy = 1'b0;
    chk("ovr_no_start", n, 0);
    chk("ovr_set", Overrun, 1);

    // Pause during an in-flight conversion.
    wait_start(40, s);
    chk("pause_addr", Conv_Addr, 3);
    Conv_Busy = 1'b1;
    step(1);
    Switch = 2'b11;
    step(4);
    Conv_Done = 1'b1;
    Conv_RetAddr = Conv_Addr;
    Conv_Data = 12'h333;
    step(1);
    Conv_Done = 1'b0;
    Conv_Busy = 1'b0;
    step(1);
    chk("pause_valid", Res_Valid, 1);
    chk("pause_data", Res_Data, 12'h333);
    count_starts(60, n);
    chk("pause_no_start", n, 0);

    // Reset in the middle of a frame.
    Switch = 2'b01;
    wait_start(40, s);
    chk("rm_addr", Conv_Addr, 3);
    Conv_Busy = 1'b1;
    step(2);
    #2 RST = 1'b1;
    #1;
    chk("rm_conv_addr", Conv_Addr, 0);
    chk("rm_res", {Res_Valid, Res_Addr, Res_Data}, 0);
    chk("rm_flags", {Err_Addr, Err_Timeout, Overrun}, 0);
    for (int a = 0; a < 8; a++) begin
      Rd_Addr = 3'(a);
      #1 chk($sformatf("rm_file%0d", a), Rd_Data, 0);
    end
    Conv_Busy = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    wait_start(40, s);
    chk("rm_first_addr", Conv_Addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ad_scan_scheduler.md
# ad_scan_scheduler

Channel scheduler that sequences the serial ADC transaction engine inside `AD_Top`. It paces conversions with a sample-rate timer and selects the next channel address according to the 2-bit `Switch` mode. It checks the channel address echoed in each returned frame and stores every valid 12-bit result in an 8-entry per-channel result file. It sits between the board-level mode switches and the SPI engine that drives `SCLK`/`CS`/`SDO`/`SDI`, and feeds the BCD/display path.

## Interface
- `SAMPLE_PERIOD`, default 5000: `CLK` cycles between conversion ticks. At 50 MHz this gives 10 kS/s. Legal range is 2..65535.
- `TIMEOUT`, default 1024: maximum number of `CLK` cycles in `WAIT_DONE` before the scheduler aborts. Legal range is 2..65535.

- `CLK` in 1: system clock; all state changes on its rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `Switch` in 2: scan mode.
  - 00: single channel `Sel_Ch`.
  - 01: scan channels 0..3.
  - 10: scan channels 0..7.
  - 11: pause.
- `Sel_Ch` in 3: channel used in mode 00.
- `Conv_Start` out 1: one-cycle request pulse to the SPI engine.
- `Conv_Addr` out 3: channel address for the request; held stable from `Conv_Start` until `Conv_Done`.
- `Conv_Busy` in 1: SPI engine is busy with a frame.
- `Conv_Done` in 1: one-cycle pulse marking the end of a frame.
- `Conv_Data` in 12: conversion result; valid while `Conv_Done` is high.
- `Conv_RetAddr` in 3: channel address echoed in the frame; valid while `Conv_Done` is high.
- `Res_Valid` out 1: one-cycle pulse announcing a new result.
- `Res_Addr` out 3: channel of the last result.
- `Res_Data` out 12: data of the last result.
- `Rd_Addr` in 3: read address into the result file.
- `Rd_Data` out 12: result file entry for `Rd_Addr`; combinational read.
- `Err_Clr` in 1: clears all sticky error flags.
- `Err_Addr` out 1: sticky flag; echoed address did not match the request.
- `Err_Timeout` out 1: sticky flag; no `Conv_Done` arrived within `TIMEOUT` cycles.
- `Overrun` out 1: sticky flag; a tick arrived while a conversion was still outstanding.

## Operation
Reset values:
- All outputs are 0.
- The result file is all zeros.
- The channel pointer `ch` is 0.
- The timer is 0.
- The state is `IDLE`.

Sample timer:
- Counts 0..`SAMPLE_PERIOD`-1 and wraps to 0.
- `tick` is asserted for one cycle when the count equals `SAMPLE_PERIOD`-1.
- In mode 11 the timer is held at 0 and no tick is generated.

State machine, one transition per cycle:
- `IDLE`, on `tick` with `Conv_Busy`=0: load `Conv_Addr`. The address is `Sel_Ch` in mode 00, otherwise `ch`. Pulse `Conv_Start`, then go to `WAIT_DONE`.
- `IDLE`, on `tick` with `Conv_Busy`=1: set `Overrun`, drop the tick, stay in `IDLE`.
- `WAIT_DONE`, on `Conv_Done`:
  - If `Conv_RetAddr`==`Conv_Addr`, go to `STORE`.
  - Otherwise set `Err_Addr`, discard the data, advance `ch`, and go to `IDLE`.
- `WAIT_DONE`, on a tick: set `Overrun` and drop the tick. The state does not change.
- `WAIT_DONE`, after `TIMEOUT` cycles without `Conv_Done`: set `Err_Timeout`, advance `ch`, go to `IDLE`.
- `STORE`:
  - Write the captured data into `file[Conv_Addr]`.
  - Update `Res_Addr` and `Res_Data`, and pulse `Res_Valid`.
  - Advance `ch`, then go to `IDLE`.

Channel advance:
- Mode 01: (`ch`+1) mod 4.
- Mode 10: (`ch`+1) mod 8.
- Modes 00 and 11: `ch` is unchanged.
- Whenever `ch` is outside the range of the current mode (for example `ch`=5 in mode 01), it is forced to 0 on the next cycle.

Mode changes and clearing:
- Entering mode 11 while in `WAIT_DONE` lets the in-flight conversion complete normally. No new request is issued after it.
- `Err_Clr` clears all sticky flags. If a new error event occurs in the same cycle as `Err_Clr`, the event wins and the flag ends up set.

Reset during operation: `RST` asserted in any state returns the block to the reset values immediately and asynchronously. The SPI engine is responsible for aborting its own frame.

## Timing
- A tick observed in cycle T produces `Conv_Start` in cycle T+1, driven by a register.
- `Conv_Done` in cycle D produces `Res_Valid`, `Res_Data`, and the updated `Rd_Data` in cycle D+2: one cycle for the address check, one cycle for the `STORE` state.
- The earliest next request is on the next tick. The minimum spacing between requests is `SAMPLE_PERIOD` cycles.
- Timeout is counted from the cycle after `Conv_Start`. The abort takes effect in cycle `Conv_Start`+`TIMEOUT`+1.
- `Rd_Data` reflects a write in the cycle after the write edge.

## Structure
Package `ad_pkg` contains:
- Mode encodings `MODE_SINGLE`, `MODE_SCAN4`, `MODE_SCAN8`, `MODE_PAUSE`.
- The state enum `IDLE`, `WAIT_DONE`, `STORE`.
- The constants `AD_WIDTH`=12 and `AD_NCH`=8.

Sub-module `ad_sample_timer` takes parameter `SAMPLE_PERIOD` and has ports `CLK`, `RST`, `en`, `tick`. The FSM, the channel pointer, and the result file live in the top-level module.

## Test plan
- **Scan 0..3:** `Switch`=01, `SAMPLE_PERIOD`=20, engine model echoes the address with data 0x100+addr.
  - Requests go to addresses 0,1,2,3,0 exactly 20 cycles apart.
  - `Rd_Data` for address 2 reads 0x102.
- **Single channel:** `Switch`=00, `Sel_Ch`=6, engine returns data 0xABC.
  - Every request uses address 6.
  - `Res_Valid` fires 2 cycles after each `Conv_Done`, with `Res_Data`=0xABC.
- **Address mismatch:** request address 3, engine echoes 5.
  - `Err_Addr`=1, no `Res_Valid`, and `file[3]` is unchanged.
  - `Err_Clr` returns `Err_Addr` to 0.
- **Timeout:** `TIMEOUT`=8, engine never pulses `Conv_Done`.
  - `Err_Timeout` rises 9 cycles after `Conv_Start`.
  - The next request goes to the next channel.
- **Overrun and pause:** hold `Conv_Busy` high across a tick, then switch to mode 11 in the middle of a conversion.
  - The tick sets `Overrun`.
  - The in-flight result is still stored, and no further `Conv_Start` is issued.
- **Reset mid-frame:** assert `RST` during `WAIT_DONE`.
  - All outputs and the result file are 0 immediately.
  - After `RST` is released, the first request goes to address 0.
